pcs_scrambler_pipe: RTL and testbench

//  Parametrised self-synchronous scrambler/descrambler, g(x) = x^58 + x^39 + 1, for the 40G/100G PCS

---
 rtl/pcs_scrambler_pipe.sv | 124 ++++++++++++
 tb/tb_pcs_scrambler_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_scrambler_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pcs_scrambler_pipe
// Purpose  : Self-synchronous x^58 + x^39 + 1 scrambler/descrambler with a
//            single valid/ready register stage, bypass, seed load and sync flag.
// Revision : 1.0
// ============================================================================
module pcs_scrambler_pipe #(
  parameter int          DATA_WIDTH = 64,
  parameter bit          DESCRAMBLE = 1'b0,
  parameter logic [57:0] SEED_INIT  = 58'h3FF_FFFF_FFFF_FFFF,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_bypass,
  input  logic                  seed_load,
  input  logic [57:0]           seed_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  synced,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int                SYNC_BEATS = (58 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int                SYNC_W     = $clog2(SYNC_BEATS + 1);
  localparam logic [SYNC_W-1:0] SYNC_MAX   = SYNC_W'(SYNC_BEATS);

  // Returns {next_state, processed_data}. The extended vector holds the 58
  // history bits below the beat's scrambled-domain bits, so every tap is a
  // plain index and narrow beats fall out without special cases.
  function automatic logic [DATA_WIDTH+57:0] lfsr_step(
    input logic [57:0]           state,
    input logic [DATA_WIDTH-1:0] din
  );
    logic [DATA_WIDTH+57:0] ext;
    logic [DATA_WIDTH-1:0]  dout;
    ext  = {{DATA_WIDTH{1'b0}}, state};
    dout = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (DESCRAMBLE) begin
        ext[58+i] = din[i];
        dout[i]   = din[i] ^ ext[i+19] ^ ext[i];
      end else begin
        ext[58+i] = din[i] ^ ext[i+19] ^ ext[i];
        dout[i]   = ext[58+i];
      end
    end
    return {ext[DATA_WIDTH+57:DATA_WIDTH], dout};
  endfunction

  logic [57:0]            state_q,    state_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   synced_q,   synced_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SYNC_W-1:0]      sync_cnt_q, sync_cnt_d;
  logic [DATA_WIDTH+57:0] step;
  logic                   accept;

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign step      = lfsr_step(state_q, in_data);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign synced    = synced_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;
    sync_cnt_d  = sync_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_bypass ? in_data : step[DATA_WIDTH-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && !in_bypass) begin
      state_d    = step[DATA_WIDTH+57:DATA_WIDTH];
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (sync_cnt_q != SYNC_MAX) begin
        sync_cnt_d = sync_cnt_q + 1'b1;
      end
    end

    // A coincident beat has already used the old state; the seed takes the next one.
    if (seed_load) begin
      state_d    = seed_value;
      sync_cnt_d = '0;
    end

    synced_d = (sync_cnt_d == SYNC_MAX);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED_INIT;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      synced_q    <= 1'b0;
      beat_cnt_q  <= '0;
      sync_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      synced_q    <= synced_d;
      beat_cnt_q  <= beat_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcs_scrambler_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_scrambler_pipe
// Purpose  : Scoreboard bench: 64-bit scrambler->descrambler loop plus a
//            standalone 16-bit descrambler.
// Revision : 1.0
// ============================================================================
module tb_pcs_scrambler_pipe;

  localparam logic [57:0] SEED_INIT = 58'h3FF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] d;
    bit          chk;
  } dexp_t;

  logic        CLK = 1'b0;
  logic        rst_n;

  logic        scr_in_valid, scr_in_ready, scr_in_bypass, scr_seed_load;
  logic [63:0] scr_in_data, scr_out_data;
  logic [57:0] scr_seed_value;
  logic        scr_out_valid, scr_synced;
  logic [3:0]  scr_beat_cnt;

  logic        dsc_in_ready, dsc_out_valid, dsc_out_ready, dsc_synced;
  logic [63:0] dsc_out_data;
  logic [31:0] dsc_beat_cnt;

  logic        d16_in_valid, d16_in_ready, d16_in_bypass, d16_seed_load;
  logic [15:0] d16_in_data, d16_out_data;
  logic [57:0] d16_seed_value;
  logic        d16_out_valid, d16_synced;
  logic [31:0] d16_beat_cnt;

  int          n_vec  = 0;
  int          n_miss = 0;

  logic [63:0] q_scr[$];
  dexp_t       q_dsc[$];
  logic [15:0] q16[$];

  logic [57:0] m_scr;
  logic [3:0]  exp_cnt;
  bit          dc_next;
  logic [57:0] m16;
  int          n16;

  pcs_scrambler_pipe #(.DATA_WIDTH(64), .DESCRAMBLE(1'b0), .SEED_INIT(SEED_INIT), .CNT_WIDTH(4)) u_scr (
    .CLK(CLK), .rst_n(rst_n),
    .in_valid(scr_in_valid), .in_ready(scr_in_ready), .in_data(scr_in_data),
    .in_bypass(scr_in_bypass), .seed_load(scr_seed_load), .seed_value(scr_seed_value),
    .out_valid(scr_out_valid), .out_ready(dsc_in_ready), .out_data(scr_out_data),
    .synced(scr_synced), .beat_cnt(scr_beat_cnt)
  );

  pcs_scrambler_pipe #(.DATA_WIDTH(64), .DESCRAMBLE(1'b1), .SEED_INIT(SEED_INIT), .CNT_WIDTH(32)) u_dsc (
    .CLK(CLK), .rst_n(rst_n),
    .in_valid(scr_out_valid), .in_ready(dsc_in_ready), .in_data(scr_out_data),
    .in_bypass(1'b0), .seed_load(1'b0), .seed_value(58'h0),
    .out_valid(dsc_out_valid), .out_ready(dsc_out_ready), .out_data(dsc_out_data),
    .synced(dsc_synced), .beat_cnt(dsc_beat_cnt)
  );

  pcs_scrambler_pipe #(.DATA_WIDTH(16), .DESCRAMBLE(1'b1), .SEED_INIT(SEED_INIT), .CNT_WIDTH(32)) u_d16 (
    .CLK(CLK), .rst_n(rst_n),
    .in_valid(d16_in_valid), .in_ready(d16_in_ready), .in_data(d16_in_data),
    .in_bypass(d16_in_bypass), .seed_load(d16_seed_load), .seed_value(d16_seed_value),
    .out_valid(d16_out_valid), .out_ready(1'b1), .out_data(d16_out_data),
    .synced(d16_synced), .beat_cnt(d16_beat_cnt)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Serial reference: one bit at a time through a 58-bit history register.
  function automatic logic [121:0] model_scr(input logic [57:0] st, input logic [63:0] d);
    logic [57:0] h;
    logic [63:0] o;
    h = st;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ h[0] ^ h[19];
      h    = {o[i], h[57:1]};
    end
    return {h, o};
  endfunction

  function automatic logic [73:0] model_dsc16(input logic [57:0] st, input logic [15:0] d);
    logic [57:0] h;
    logic [15:0] o;
    h = st;
    for (int i = 0; i < 16; i++) begin
      o[i] = d[i] ^ h[0] ^ h[19];
      h    = {d[i], h[57:1]};
    end
    return {h, o};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input bit byp, input bit sl, input logic [57:0] sv);
    int          waitc;
    logic [121:0] r;
    dexp_t       e;
    scr_in_valid   = 1'b1;
    scr_in_data    = d;
    scr_in_bypass  = byp;
    scr_seed_load  = sl;
    scr_seed_value = sv;
    waitc = 0;
    @(negedge CLK);
    while (!scr_in_ready && waitc < 100) begin
      waitc++;
      @(negedge CLK);
    end
    if (!scr_in_ready) begin
      check_value("accept_timeout", {63'b0, scr_in_ready}, 64'h1);
    end else begin
      r = model_scr(m_scr, d);
      e.d = d;
      if (byp) begin
        q_scr.push_back(d);
        e.chk   = 1'b0;
        dc_next = 1'b1;
      end else begin
        q_scr.push_back(r[63:0]);
        m_scr   = r[121:64];
        exp_cnt = exp_cnt + 4'd1;
        e.chk   = !dc_next;
        dc_next = 1'b0;
      end
      q_dsc.push_back(e);
      if (sl) begin
        m_scr   = sv;
        dc_next = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    scr_in_valid  = 1'b0;
    scr_seed_load = 1'b0;
  endtask

  task automatic load_seed(input logic [57:0] sv);
    scr_seed_load  = 1'b1;
    scr_seed_value = sv;
    @(posedge CLK);
    #1;
    scr_seed_load = 1'b0;
    m_scr   = sv;
    dc_next = 1'b1;
  endtask

  task automatic d16_beat(input logic [15:0] d, input bit byp);
    logic [73:0] r;
    d16_in_valid  = 1'b1;
    d16_in_data   = d;
    d16_in_bypass = byp;
    @(negedge CLK);
    r = model_dsc16(m16, d);
    if (byp) begin
      q16.push_back(d);
    end else begin
      q16.push_back(r[15:0]);
      m16 = r[73:16];
      if (n16 < 4) n16++;
    end
    @(posedge CLK);
    #1;
    d16_in_valid = 1'b0;
    check_value("d16_synced", {63'b0, d16_synced}, {63'b0, (n16 == 4)});
  endtask

  always @(negedge CLK) begin
    if (rst_n) begin
      if (scr_out_valid && dsc_in_ready) begin
        if (q_scr.size() == 0) check_value("scr_unexpected", {63'b0, scr_out_valid}, 64'h0);
        else check_value("scr_data", scr_out_data, q_scr.pop_front());
      end
      if (dsc_out_valid && dsc_out_ready) begin
        if (q_dsc.size() == 0) begin
          check_value("loop_unexpected", {63'b0, dsc_out_valid}, 64'h0);
        end else begin
          dexp_t e;
          e = q_dsc.pop_front();
          if (e.chk) check_value("loop_data", dsc_out_data, e.d);
        end
      end
      if (d16_out_valid) begin
        if (q16.size() == 0) check_value("d16_unexpected", {63'b0, d16_out_valid}, 64'h0);
        else check_value("d16_data", {48'b0, d16_out_data}, {48'b0, q16.pop_front()});
      end
    end
  end

  initial begin
    logic [63:0] held;
    rst_n = 1'b0;
    scr_in_valid = 1'b0; scr_in_data = '0; scr_in_bypass = 1'b0;
    scr_seed_load = 1'b0; scr_seed_value = '0;
    dsc_out_ready = 1'b1;
    d16_in_valid = 1'b0; d16_in_data = '0; d16_in_bypass = 1'b0;
    d16_seed_load = 1'b0; d16_seed_value = '0;
    m_scr = SEED_INIT; exp_cnt = '0; dc_next = 1'b0;
    m16 = SEED_INIT; n16 = 0;
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;

    // reset state
    check_value("rst_out_valid", {63'b0, scr_out_valid}, 64'h0);
    check_value("rst_out_data", scr_out_data, 64'h0);
    check_value("rst_synced", {63'b0, scr_synced}, 64'h0);
    check_value("rst_beat_cnt", {60'b0, scr_beat_cnt}, 64'h0);
    check_value("rst_in_ready", {63'b0, scr_in_ready}, 64'h1);
    check_value("rst_d16_synced", {63'b0, d16_synced}, 64'h0);

    // known vector from a zero seed
    load_seed(58'h0);
    send(64'h1, 1'b0, 1'b0, 58'h0);
    check_value("t1_valid", {63'b0, scr_out_valid}, 64'h1);
    check_value("t1_data", scr_out_data, 64'h0400_0080_0000_0001);
    check_value("t1_cnt", {60'b0, scr_beat_cnt}, {60'b0, exp_cnt});
    check_value("t1_synced", {63'b0, scr_synced}, 64'h1);

    // bypass beat leaves counter and state alone
    send(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 58'h0);
    check_value("byp_cnt", {60'b0, scr_beat_cnt}, {60'b0, exp_cnt});
    send(64'h1111_2222_3333_4444, 1'b0, 1'b0, 58'h0);

    // seed coincident with accept
    send(64'hCAFE_F00D_0000_FFFF, 1'b0, 1'b1, 58'h2AB_CDEF_0123_4567);
    check_value("seed_co_synced", {63'b0, scr_synced}, 64'h0);
    send(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 58'h0);
    check_value("seed_co_synced2", {63'b0, scr_synced}, 64'h1);

    // counter wrap
    while (exp_cnt != 4'd15) send({$urandom, $urandom}, 1'b0, 1'b0, 58'h0);
    check_value("cnt_15", {60'b0, scr_beat_cnt}, 64'd15);
    send({$urandom, $urandom}, 1'b0, 1'b0, 58'h0);
    check_value("cnt_wrap", {60'b0, scr_beat_cnt}, 64'd0);

    // long random loopback
    for (int k = 0; k < 10000; k++) send({$urandom, $urandom}, 1'b0, 1'b0, 58'h0);
    check_value("dsc_synced", {63'b0, dsc_synced}, 64'h1);

    // back-pressure with continuous input
    fork
      begin
        for (int k = 0; k < 20; k++) send({$urandom, $urandom}, 1'b0, 1'b0, 58'h0);
      end
      begin
        repeat (3) @(posedge CLK);
        #1 dsc_out_ready = 1'b0;
        @(negedge CLK);
        held = dsc_out_data;
        check_value("bp_valid0", {63'b0, dsc_out_valid}, 64'h1);
        for (int k = 0; k < 5; k++) begin
          @(negedge CLK);
          check_value("bp_stable", dsc_out_data, held);
        end
        check_value("bp_dsc_in_ready", {63'b0, dsc_in_ready}, 64'h0);
        check_value("bp_scr_in_ready", {63'b0, scr_in_ready}, 64'h0);
        @(posedge CLK);
        #1 dsc_out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge CLK);
    #1;
    check_value("drain_scr", q_scr.size(), 64'd0);
    check_value("drain_dsc", q_dsc.size(), 64'd0);

    // 16-bit descrambler sync
    d16_beat(16'h1234, 1'b0);
    d16_beat(16'hBEEF, 1'b0);
    d16_beat(16'hAAAA, 1'b1);
    d16_beat(16'h5555, 1'b0);
    d16_beat(16'h0F0F, 1'b0);
    d16_seed_load  = 1'b1;
    d16_seed_value = 58'h155_5555_0000_AAAA;
    @(posedge CLK);
    #1 d16_seed_load = 1'b0;
    m16 = 58'h155_5555_0000_AAAA;
    n16 = 0;
    check_value("d16_seed_clr", {63'b0, d16_synced}, 64'h0);
    d16_beat(16'h8001, 1'b0);
    repeat (2) @(posedge CLK);
    #1 check_value("drain_d16", q16.size(), 64'd0);

    // asynchronous reset with a beat in flight
    dsc_out_ready = 1'b0;
    send({$urandom, $urandom}, 1'b0, 1'b0, 58'h0);
    send({$urandom, $urandom}, 1'b0, 1'b0, 58'h0);
    #3 rst_n = 1'b0;
    #1;
    q_scr.delete();
    q_dsc.delete();
    check_value("arst_scr_valid", {63'b0, scr_out_valid}, 64'h0);
    check_value("arst_dsc_valid", {63'b0, dsc_out_valid}, 64'h0);
    check_value("arst_state", {6'b0, u_scr.state_q}, {6'b0, SEED_INIT});
    check_value("arst_cnt", {60'b0, scr_beat_cnt}, 64'h0);
    dsc_out_ready = 1'b1;
    #12 rst_n = 1'b1;
    @(posedge CLK);
    #1 check_value("post_rst_ready", {63'b0, scr_in_ready}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
